instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Writer side of the instruction-memory read port used by the CPU FSM. Receives a program as a
//  byte stream (valid/ready), assembles instruction words and writes them into instruction memory
//  from address 0. Holds the CPU in reset while loading, then hands the memory port to the CPU.
//  Sits between the host/UART byte source, the instruction SRAM and the CPU FSM.
// PARAMETERS
//  M  4  register address width; instruction word width W = 4+2*M (default 12, must be <= 16)
//  P  6  PC / instruction-memory address width; memory depth 2**P words
// PORTS
//  clk                     in   1  clock
//  rst_n                   in   1  asynchronous, active-low reset
//  load_req                in   1  1-cycle pulse: start (or restart) a program load
//  in_valid                in   1  byte source has a byte on in_data
//  in_data                 in   8  stream byte
//  in_ready                out  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
//  cpu_rst_n               out  1  synchronous reset to CPU FSM; 0 = CPU held in reset
//  cpu_en_read_instr       in   1  CPU instruction-read enable
//  cpu_read_address_instr  in   P  CPU instruction-read address
//  mem_en                  out  1  instruction memory enable
//  mem_we                  out  1  instruction memory write enable
//  mem_addr                out  P  instruction memory address
//  mem_wdata               out  W  instruction memory write data
//  busy / done / error     out  1  status: loading / program loaded, CPU running / load failed
// BEHAVIOUR
//  States: IDLE, HDR, LO, HI, WR, CHK, RUN, ERR. Reset -> IDLE; all outputs 0 (cpu_rst_n=0).
//  Frame: HDR byte h (count-1), then per word LO byte, HI byte, then one CHK byte.
//  IDLE: in_ready=0, CPU held. load_req -> HDR.
//  HDR: in_ready=1. On transfer: clear addr counter, csum=h; if h > 2**P-1 -> ERR, else len=h+1 -> LO.
//  LO: in_ready=1; transfer latches low byte, csum^=byte -> HI.
//  HI: in_ready=1; transfer latches high byte, csum^=byte -> WR. Word = {hi,lo}[W-1:0];
//   bits [15:W] ignored but still included in checksum.
//  WR: in_ready=0; exactly one cycle mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=word.
//   If addr==len-1 -> CHK else addr+1 -> LO. Counter is P+1 bits; no wrap past 2**P-1.
//  CHK: in_ready=1; on transfer, byte==csum -> RUN else -> ERR.
//  RUN: cpu_rst_n=1, done=1; mem_en=cpu_en_read_instr, mem_addr=cpu_read_address_instr, mem_we=0.
//   First cycle with cpu_rst_n=1 is the cycle after the CHK transfer.
//  ERR: error=1, CPU held, in_ready=0; stays until load_req.
//  busy=1 in HDR,LO,HI,WR,CHK. cpu_rst_n=0 in every state except RUN.
//  Outside RUN and WR: mem_en=mem_we=0, mem_addr=0, mem_wdata=0; CPU read requests ignored.
//  load_req has priority in every state (incl. mid-frame, WR, RUN, ERR): next state HDR, csum
//   and counter cleared, error/done cleared next cycle. A WR in progress when load_req
//   arrives still completes its write in that cycle.
//  in_valid with in_ready=0 is not consumed; source must hold the byte.
//  Already-written words are not erased on ERR or abort; CPU cannot run until a good load.
//  rst_n low mid-load: immediate return to IDLE, no further memory writes.
// TESTING
//  T1 load_req; bytes 01,BC,0A,23,01,95 -> writes [0]=0xABC, [1]=0x123; done=1, cpu_rst_n=1
//   one cycle after last byte.
//  T2 same frame, CHK=0x94 -> error=1, cpu_rst_n stays 0, no RUN; then load_req + T1 -> done=1.
//  T3 header 0x40 (65 words, P=6) -> ERR immediately, no mem_we pulses.
//  T4 header 0x3F, 64 words, random in_valid gaps -> 64 writes at addr 0..63, no wrap, csum ok.
//  T5 RUN: cpu_en_read_instr=1, addr 0x01 -> mem_en=1, mem_addr=0x01, mem_we=0;
//   load_req -> cpu_rst_n=0 next cycle.
//  T6 rst_n low after 3rd byte of T1 -> all outputs at reset values, no further writes.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Loads a byte-stream program into instruction memory from address 0, then hands the memory read port to the CPU.
// Latency: one write cycle per word after its HI byte; CPU leaves reset the cycle after a matching checksum byte.
// Backpressure: in_ready is low in IDLE, WR, RUN and ERR; an offered byte is held by the source until accepted.
module instr_mem_loader #(
  parameter  int M = 4,
  parameter  int P = 6,
  localparam int W = 4 + 2 * M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_req,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         cpu_rst_n,
  input  logic         cpu_en_read_instr,
  input  logic [P-1:0] cpu_read_address_instr,
  output logic         mem_en,
  output logic         mem_we,
  output logic [P-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LO, S_HI, S_WR, S_CHK, S_RUN, S_ERR
  } state_t;

  // Largest legal header: one less than the memory depth.
  localparam logic [7:0] MAX_HDR  = 8'((2 ** P) - 1);
  localparam logic [P:0] ADDR_ONE = (P + 1)'(1);

  state_t         state;
  state_t         state_nxt;
  logic [P:0]     addr;      // one spare bit so the counter can never wrap silently
  logic [P-1:0]   last;      // header value = address of the final word
  logic [7:0]     csum;
  logic [7:0]     lo_byte;
  logic [W-1:0]   word;
  logic           accept;
  logic           xfer;

  // Byte-accepting states; a transfer needs both sides.
  assign accept   = (state == S_HDR) || (state == S_LO) || (state == S_HI) || (state == S_CHK);
  assign in_ready = accept;
  assign xfer     = in_valid & accept;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Frame datapath: address counter, running checksum, word assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      last    <= '0;
      csum    <= '0;
      lo_byte <= '0;
      word    <= '0;
    end else if (load_req) begin
      addr <= '0;
      csum <= '0;
    end else begin
      case (state)
        S_HDR: if (xfer) begin
          addr <= '0;
          csum <= in_data;
          last <= in_data[P-1:0];
        end
        S_LO: if (xfer) begin
          lo_byte <= in_data;
          csum    <= csum ^ in_data;
        end
        S_HI: if (xfer) begin
          // Upper bits of the high byte are dropped from the word but still checksummed.
          word <= W'({in_data, lo_byte});
          csum <= csum ^ in_data;
        end
        S_WR: if (addr != {1'b0, last}) addr <= addr + ADDR_ONE;
        default: ;
      endcase
    end
  end

  // Next state and Moore-style outputs; memory port is muxed between loader and CPU.
  always_comb begin
    state_nxt = state;
    cpu_rst_n = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE: ;
      S_HDR: begin
        busy = 1'b1;
        if (xfer) state_nxt = (in_data > MAX_HDR) ? S_ERR : S_LO;
      end
      S_LO: begin
        busy = 1'b1;
        if (xfer) state_nxt = S_HI;
      end
      S_HI: begin
        busy = 1'b1;
        if (xfer) state_nxt = S_WR;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr[P-1:0];
        mem_wdata = word;
        state_nxt = (addr == {1'b0, last}) ? S_CHK : S_LO;
      end
      S_CHK: begin
        busy = 1'b1;
        if (xfer) state_nxt = (in_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        cpu_rst_n = 1'b1;
        done      = 1'b1;
        mem_en    = cpu_en_read_instr;
        mem_addr  = cpu_read_address_instr;
      end
      S_ERR: error = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
    // A new load request overrides everything, even mid-frame.
    if (load_req) state_nxt = S_HDR;
  end

endmodule
